// File: rtl/mem_wb_pkg.sv
// Shared encodings for the execute/writeback stage: RV32I opcodes, load/store
// func3 values and the memory-access FSM state type.
package mem_wb_pkg;

    // Opcode field is instruction[6:2]; the constant low bits 2'b11 are dropped.
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Instructions whose writeback value is the ALU result.
    function automatic logic writes_alu(input logic [4:0] opc);
        return (opc == OPC_LUI) || (opc == OPC_AUIPC) ||
               (opc == OPC_OP_IMM) || (opc == OPC_OP);
    endfunction

endpackage

// File: rtl/mem_wb_stage_lsu_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and the
// misaligned / illegal-func3 fault flag. Purely combinational.
module lsu_align
    import mem_wb_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic        is_store,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = read_data[{addr, 3'b000} +: 8];
    assign half_sel = addr[1] ? read_data[31:16] : read_data[15:0];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = read_data;
        fault     = 1'b0;
        if (is_store) begin
            case (func3)
                F3_SB: begin
                    be    = 4'b0001 << addr;
                    wdata = {4{store_data[7:0]}};
                end
                F3_SH: begin
                    be    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{store_data[15:0]}};
                    fault = addr[0];
                end
                F3_SW:   fault = (addr != 2'b00);
                default: fault = 1'b1;
            endcase
        end else begin
            case (func3)
                F3_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
                F3_LBU: load_data = {24'd0, byte_sel};
                F3_LH: begin
                    load_data = {{16{half_sel[15]}}, half_sel};
                    fault     = addr[0];
                end
                F3_LHU: begin
                    load_data = {16'd0, half_sel};
                    fault     = addr[0];
                end
                F3_LW:   fault = (addr != 2'b00);
                default: fault = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Execute/writeback stage: data-memory req/ack FSM with timeout, registered
// bus outputs and the register-file writeback mux.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_ppl,
    input  logic [31:0] PC_ppl,
    input  logic [31:0] ALU_ppl,
    input  logic [31:0] rdata2_forwarded_ppl,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    output logic [31:0] wdata,
    output logic        reg_wr,
    output logic        stall_mem,
    output logic        mem_exc,
    output logic        bus_err
);

    logic [4:0] opcode;
    logic [4:0] rd;
    logic [2:0] func3;
    logic       is_load;
    logic       is_store;
    logic       unused_bits;

    assign opcode      = instruction_ppl[6:2];
    assign rd          = instruction_ppl[11:7];
    assign func3       = instruction_ppl[14:12];
    assign is_load     = (opcode == OPC_LOAD);
    assign is_store    = (opcode == OPC_STORE);
    assign unused_bits = ^{instruction_ppl[31:15], instruction_ppl[1:0]};

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        load_q;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_fault;

    // Upstream holds the instruction and address until DONE, so the captured
    // word is extracted with the live func3/addr bits.
    lsu_align u_align (
        .func3      (func3),
        .is_store   (is_store),
        .addr       (ALU_ppl[1:0]),
        .store_data (rdata2_forwarded_ppl),
        .read_data  (load_q),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .fault      (al_fault)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_wdata <= '0;
            dbus_be    <= '0;
            load_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((is_load || is_store) && !al_fault) begin
                        state      <= REQ;
                        cnt        <= '0;
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_addr  <= {ALU_ppl[31:2], 2'b00};
                        dbus_wdata <= al_wdata;
                        dbus_be    <= al_be;
                    end
                end
                REQ: begin
                    // A same-cycle ack takes priority over the timeout.
                    if (dbus_ack) begin
                        load_q   <= dbus_rdata;
                        dbus_req <= 1'b0;
                        cnt      <= '0;
                        state    <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        dbus_req <= 1'b0;
                        cnt      <= '0;
                        state    <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_mem = 1'b0;
        reg_wr    = 1'b0;
        wdata     = ALU_ppl;
        mem_exc   = 1'b0;
        bus_err   = 1'b0;
        case (state)
            IDLE: begin
                if (is_load || is_store) begin
                    if (al_fault) mem_exc   = 1'b1;
                    else          stall_mem = 1'b1;
                end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
                    reg_wr = 1'b1;
                    wdata  = PC_ppl + 32'd4;
                end else if (writes_alu(opcode)) begin
                    reg_wr = 1'b1;
                end
            end
            REQ:  stall_mem = 1'b1;
            DONE: begin
                if (is_load) begin
                    reg_wr = 1'b1;
                    wdata  = al_load;
                end
            end
            ERR:     bus_err = 1'b1;
            default: ;
        endcase
        if (rd == 5'd0) reg_wr = 1'b0;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus tasks queue expected bus,
// writeback and fault events; a negedge monitor pops and compares them.
module tb_mem_wb_stage;

    localparam int TIMEOUT = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_ppl, PC_ppl, ALU_ppl, rdata2_forwarded_ppl;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        dbus_req, dbus_we, reg_wr, stall_mem, mem_exc, bus_err;
    logic [31:0] dbus_addr, dbus_wdata, wdata;
    logic [3:0]  dbus_be;

    mem_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction_ppl      (instruction_ppl),
        .PC_ppl               (PC_ppl),
        .ALU_ppl              (ALU_ppl),
        .rdata2_forwarded_ppl (rdata2_forwarded_ppl),
        .dbus_rdata           (dbus_rdata),
        .dbus_ack             (dbus_ack),
        .dbus_req             (dbus_req),
        .dbus_we              (dbus_we),
        .dbus_addr            (dbus_addr),
        .dbus_wdata           (dbus_wdata),
        .dbus_be              (dbus_be),
        .wdata                (wdata),
        .reg_wr               (reg_wr),
        .stall_mem            (stall_mem),
        .mem_exc              (mem_exc),
        .bus_err              (bus_err)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_BUS, EV_WB, EV_EXC, EV_BERR} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        we;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'd0, f3, rd, opc};
    endfunction

    task automatic push(input ev_kind_e k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic we);
        ev_t e;
        e = '{kind: k, a: a, d: d, be: be, we: we};
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(input ev_kind_e k, output ev_t e, output logic got);
        e   = '{kind: k, a: '0, d: '0, be: '0, we: 1'b0};
        got = 1'b0;
        if (exp_q.size() == 0) begin
            check("unexpected event kind", 32'(k), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("event kind", 32'(k), 32'(e.kind));
            got = (e.kind == k);
        end
    endtask

    // Monitor: every observable DUT event must match the head of the queue.
    always @(negedge clk) begin
        ev_t  e;
        logic got;
        if (!rst) begin
            if (dbus_req && dbus_ack) begin
                pop_exp(EV_BUS, e, got);
                if (got) begin
                    check("bus addr", dbus_addr, e.a);
                    check("bus be", {28'd0, dbus_be}, {28'd0, e.be});
                    check("bus we", {31'd0, dbus_we}, {31'd0, e.we});
                    if (e.we) check("bus wdata", dbus_wdata, e.d);
                end
            end
            if (reg_wr) begin
                pop_exp(EV_WB, e, got);
                if (got) check("wb wdata", wdata, e.d);
            end
            if (mem_exc) pop_exp(EV_EXC, e, got);
            if (bus_err) pop_exp(EV_BERR, e, got);
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rs2);
        instruction_ppl      = ins;
        PC_ppl               = pc;
        ALU_ppl              = alu;
        rdata2_forwarded_ppl = rs2;
    endtask

    task automatic to_nop();
        @(posedge clk); #1;
        drive(NOP, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic alu_op(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] alu, input logic ewr, input logic [31:0] ewd);
        @(posedge clk); #1;
        drive(ins, pc, alu, 32'h0);
        if (ewr) push(EV_WB, 32'h0, ewd, 4'h0, 1'b0);
        @(negedge clk);
        check("alu stall_mem", {31'd0, stall_mem}, 32'd0);
        check("alu reg_wr", {31'd0, reg_wr}, {31'd0, ewr});
        to_nop();
    endtask

    // Load/store with `waits` REQ cycles before the ack cycle.
    task automatic mem_op(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [31:0] rdat, input int waits, input logic ewe,
                          input logic [3:0] ebe, input logic [31:0] ebw,
                          input logic ewr, input logic [31:0] ewd);
        push(EV_BUS, alu & ~32'h3, ebw, ebe, ewe);
        if (ewr) push(EV_WB, 32'h0, ewd, 4'h0, 1'b0);
        @(posedge clk); #1;
        drive(ins, 32'h0, alu, rs2);
        dbus_ack = 1'b0;
        @(negedge clk);
        check("issue stall_mem", {31'd0, stall_mem}, 32'd1);
        check("issue dbus_req", {31'd0, dbus_req}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("req dbus_req", {31'd0, dbus_req}, 32'd1);
            check("req stall_mem", {31'd0, stall_mem}, 32'd1);
            @(posedge clk); #1;
        end
        dbus_ack   = 1'b1;
        dbus_rdata = rdat;
        @(negedge clk);
        check("ack stall_mem", {31'd0, stall_mem}, 32'd1);
        @(posedge clk); #1;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        @(negedge clk);
        check("done stall_mem", {31'd0, stall_mem}, 32'd0);
        check("done dbus_req", {31'd0, dbus_req}, 32'd0);
        check("done reg_wr", {31'd0, reg_wr}, {31'd0, ewr});
        to_nop();
    endtask

    task automatic exc_op(input logic [31:0] ins, input logic [31:0] alu);
        push(EV_EXC, 32'h0, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        drive(ins, 32'h0, alu, 32'h5555_5555);
        @(negedge clk);
        check("exc stall_mem", {31'd0, stall_mem}, 32'd0);
        check("exc dbus_req", {31'd0, dbus_req}, 32'd0);
        to_nop();
        @(negedge clk);
        check("exc no request", {31'd0, dbus_req}, 32'd0);
    endtask

    task automatic timeout_op(input logic [31:0] ins, input logic [31:0] alu);
        push(EV_BERR, 32'h0, 32'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        drive(ins, 32'h0, alu, 32'h0);
        dbus_ack = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            check("timeout dbus_req", {31'd0, dbus_req}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("err dbus_req", {31'd0, dbus_req}, 32'd0);
        check("err stall_mem", {31'd0, stall_mem}, 32'd0);
        check("err reg_wr", {31'd0, reg_wr}, 32'd0);
        to_nop();
    endtask

    task automatic reset_mid_op(input logic [31:0] ins, input logic [31:0] alu);
        @(posedge clk); #1;
        drive(ins, 32'h0, alu, 32'h0);
        dbus_ack = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pre-reset dbus_req", {31'd0, dbus_req}, 32'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(NOP, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset dbus_req", {31'd0, dbus_req}, 32'd0);
        check("post-reset stall_mem", {31'd0, stall_mem}, 32'd0);
        @(posedge clk); #1;
        dbus_ack   = 1'b1;
        dbus_rdata = 32'h1111_2222;
        @(negedge clk);
        check("late ack dbus_req", {31'd0, dbus_req}, 32'd0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("late ack reg_wr", {31'd0, reg_wr}, 32'd0);
        check("late ack dbus_req idle", {31'd0, dbus_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(NOP, 32'h0, 32'h0, 32'h0);
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset dbus_req", {31'd0, dbus_req}, 32'd0);
        check("reset dbus_we", {31'd0, dbus_we}, 32'd0);
        check("reset dbus_addr", dbus_addr, 32'd0);
        check("reset dbus_wdata", dbus_wdata, 32'd0);
        check("reset dbus_be", {28'd0, dbus_be}, 32'd0);
        check("reset stall_mem", {31'd0, stall_mem}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Loads
        mem_op(mk(7'h03, 3'b010, 5'd5), 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF);
        mem_op(mk(7'h03, 3'b000, 5'd6), 32'h103, 32'h0, 32'h8012_3456, 0, 1'b0, 4'hF, 32'h0, 1'b1, 32'hFFFF_FF80);
        mem_op(mk(7'h03, 3'b100, 5'd6), 32'h103, 32'h0, 32'h8012_3456, 0, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_0080);
        mem_op(mk(7'h03, 3'b101, 5'd7), 32'h102, 32'h0, 32'hBEEF_0000, 0, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_BEEF);
        mem_op(mk(7'h03, 3'b001, 5'd7), 32'h100, 32'h0, 32'h1234_8001, 0, 1'b0, 4'hF, 32'h0, 1'b1, 32'hFFFF_8001);
        mem_op(mk(7'h03, 3'b000, 5'd9), 32'h101, 32'h0, 32'h0000_7F00, 0, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_007F);
        mem_op(mk(7'h03, 3'b010, 5'd0), 32'h108, 32'h0, 32'h7777_7777, 0, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0);

        // Stores (rd field carries immediate bits; never a write)
        mem_op(mk(7'h23, 3'b001, 5'd9), 32'h102, 32'h1234_ABCD, 32'h0, 0, 1'b1, 4'hC, 32'hABCD_ABCD, 1'b0, 32'h0);
        mem_op(mk(7'h23, 3'b000, 5'd3), 32'h101, 32'h0000_00A5, 32'h0, 0, 1'b1, 4'h2, 32'hA5A5_A5A5, 1'b0, 32'h0);
        mem_op(mk(7'h23, 3'b001, 5'd3), 32'h200, 32'h0000_5A3C, 32'h0, 1, 1'b1, 4'h3, 32'h5A3C_5A3C, 1'b0, 32'h0);
        mem_op(mk(7'h23, 3'b010, 5'd3), 32'h104, 32'hCAFE_F00D, 32'h0, 2, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0);

        // Misaligned and illegal func3
        exc_op(mk(7'h03, 3'b010, 5'd5), 32'h101);
        exc_op(mk(7'h23, 3'b001, 5'd1), 32'h103);
        exc_op(mk(7'h03, 3'b101, 5'd5), 32'h105);
        exc_op(mk(7'h03, 3'b011, 5'd5), 32'h100);
        exc_op(mk(7'h23, 3'b011, 5'd1), 32'h100);

        // Timeout, reset mid-access, and ack on the final allowed cycle
        timeout_op(mk(7'h03, 3'b010, 5'd5), 32'h200);
        reset_mid_op(mk(7'h03, 3'b010, 5'd5), 32'h200);
        mem_op(mk(7'h03, 3'b010, 5'd8), 32'h204, 32'h0, 32'h0BAD_F00D, TIMEOUT - 1, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0BAD_F00D);

        // Same-cycle writeback
        alu_op(mk(7'h6F, 3'b000, 5'd1), 32'h40, 32'h0,          1'b1, 32'h44);
        alu_op(mk(7'h67, 3'b000, 5'd2), 32'h80, 32'h0,          1'b1, 32'h84);
        alu_op(mk(7'h13, 3'b000, 5'd0), 32'h0,  32'h99,         1'b0, 32'h0);
        alu_op(mk(7'h37, 3'b000, 5'd3), 32'h0,  32'h1234_5000,  1'b1, 32'h1234_5000);
        alu_op(mk(7'h17, 3'b000, 5'd4), 32'h40, 32'h0000_1040,  1'b1, 32'h0000_1040);
        alu_op(mk(7'h33, 3'b000, 5'd7), 32'h0,  32'h0000_0055,  1'b1, 32'h0000_0055);
        alu_op(mk(7'h63, 3'b000, 5'd5), 32'h0,  32'h0000_0001,  1'b0, 32'h0);

        // Stray ack while idle
        @(posedge clk); #1;
        dbus_ack = 1'b1;
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("stray ack dbus_req", {31'd0, dbus_req}, 32'd0);
        check("stray ack stall_mem", {31'd0, stall_mem}, 32'd0);

        repeat (3) @(posedge clk);
        check("events outstanding", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
